deserializador: RTL and testbench
=================================

# deserializador

Serial-to-parallel receiver: the receiving end of the team's shift-register serial link. It samples one bit per enabled clock on `S_IN`, assembles `ANCHO` bits in either shift direction, and presents the word on a one-entry output buffer with a valid/ready handshake. It sits between the serial line driven by the shift-register transmitter and any parallel consumer, and it flags words lost to back-pressure.

## Interface
- `ANCHO`, default 4: data word width in bits; must be at least 2.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `ENB` input 1: sample strobe; `S_IN` is taken on a rising edge only when `ENB`=1.
- `S_IN` input 1: serial data bit.
- `DIR` input 1: bit order.
  - 0: MSB first; the partial word shifts left, new bit enters at bit 0.
  - 1: LSB first; the partial word shifts right, new bit enters at bit `ANCHO`-1.
- `SYNC` input 1: frame restart; discards the partial word.
- `LISTO` input 1: consumer ready.
- `CLR_OVF` input 1: synchronous clear of `OVF`.
- `Q` output `ANCHO`: buffered received word.
- `VALID` output 1: `Q` holds an unconsumed word.
- `OVF` output 1: sticky overrun flag.
- `ERR_PAR` output 1: parity-error pulse; tied to 0 when parity is compiled out.

## Operation
- **Reset** (asynchronous, while `RESET`=1):
  - Partial shift register = 0; bit counter = 0; state = `RECIBIENDO`.
  - `Q`=0, `VALID`=0, `OVF`=0, `ERR_PAR`=0.
- **Bit counter**: width $clog2(FRAME+1), where FRAME = `ANCHO` (plus 1 with parity enabled).
  - Increments on each `ENB` edge.
  - The frame completes on the edge that samples bit FRAME-1; the counter then wraps to 0.
- **Direction**: `DIR` is sampled on every `ENB` edge. Changing it mid-frame is legal; each bit follows the `DIR` value present on its own edge.
- **SYNC**:
  - With `ENB`=0: counter and partial word clear; no new bit is taken.
  - With `ENB`=1: the sampled bit becomes bit 0 of a new frame (counter = 1).
- **Frame completion**: the completed word goes to the output buffer if it is free, or if it is freed on the same edge.
- **Handshake**:
  - A word is consumed on an edge where `VALID`=1 and `LISTO`=1.
  - `Q` is stable while `VALID`=1 and the word is not consumed.
- **Completion and consumption on the same edge**: the new word loads into `Q` and `VALID` stays 1.
- **Overrun**: on completion with `VALID`=1 and `LISTO`=0:
  - The new word is discarded and `Q` is unchanged.
  - `OVF` is set to 1.
- **OVF clearing**: `OVF` is cleared only by `CLR_OVF` or `RESET`. If set and clear occur on the same edge, set wins.
- **States**: two.
  - `RECIBIENDO`: buffer empty.
  - `LLENO`: buffer holds a word; `VALID`=1 exactly in `LLENO`.
  - `RECIBIENDO` to `LLENO` on frame completion.
  - `LLENO` to `RECIBIENDO` on consume without a simultaneous completion.
  - `LLENO` stays `LLENO` on consume plus completion, or on overrun.
- **Serial reception never stalls**; bits keep accumulating in both states.

## Timing
- **Latency**: the last bit is sampled at edge k; `Q` and `VALID` are valid immediately after edge k.
- **Throughput**: one frame per FRAME enabled cycles; back-to-back frames need no idle bits.
- **Handshake outputs**: `VALID` is registered, with no combinational path from `LISTO` to `VALID`.
- **ERR_PAR**: a one-cycle pulse, registered at the completion edge.
- **No inter-edge delays**: all outputs change only on a `CLK` rising edge or on `RESET` assertion.

## Configuration
- **`DESERIALIZADOR_PARIDAD_EN` defined**:
  - FRAME = `ANCHO`+1; the final bit is the even-parity bit over the data bits.
  - On a match, the word proceeds normally.
  - On a mismatch, the word is discarded, `ERR_PAR` pulses for 1 cycle, and `VALID`/`Q`/`OVF` are unaffected.
  - The parity bit never enters `Q`.
  - `DIR` affects only the data bit order; the parity bit is always last.
- **Not defined**: FRAME = `ANCHO`; `ERR_PAR` is constant 0; there is no parity logic.

## Structure
- **Package `deserializador_pkg`**:
  - DIR constants `DIR_MSB_PRIMERO`=0 and `DIR_LSB_PRIMERO`=1.
  - State enum `RECIBIENDO`/`LLENO`.
  - A FRAME width function.
- **Sub-module `desp_entrada`**: the shift accumulator plus bit counter, with `SYNC`/`DIR` handling and a `fin_trama` strobe. The top level owns the buffer, handshake, `OVF`, and parity.

## Test plan
All scenarios use `ANCHO`=4, with `ENB`=1 every cycle unless noted.
- **MSB first**: `DIR`=0, `LISTO`=1, `S_IN` = 1,0,1,1 → `Q`=4'b1011 and `VALID`=1 right after the 4th edge; consumed on the next edge.
- **LSB first**: `DIR`=1, `S_IN` = 1,0,1,1 → `Q`=4'b1101.
- **Overrun and release**:
  - `LISTO`=0; send 1011 then 0110 → `Q` stays 1011 and `OVF`=1.
  - Then `LISTO`=1 → `VALID`=0 on the next edge and `OVF` stays 1.
  - Then `CLR_OVF`=1 → `OVF`=0.
- **SYNC mid-frame**: 2 bits, `SYNC` with `ENB`=0, then 0,1,1,0 → `Q`=4'b0110. Repeat with `SYNC`+`ENB` on the first 0 → same result.
- **Reset mid-frame**: 3 bits, then pulse `RESET` between edges → all outputs 0 immediately. Then 0,0,1,1 → `Q`=4'b0011.
- **Parity** (macro defined):
  - 1,0,1,1 then parity 1 → `Q`=1011, `ERR_PAR`=0.
  - 1,0,1,1 then parity 0 → `VALID` stays 0 and `ERR_PAR` pulses for 1 cycle.

Source files
------------

// File: rtl/deserializador_pkg.sv
// Shared constants, state type and frame-length helper for the deserializador receiver.
package deserializador_pkg;

  localparam logic DIR_MSB_PRIMERO = 1'b0;
  localparam logic DIR_LSB_PRIMERO = 1'b1;

  typedef enum logic {
    RECIBIENDO = 1'b0,
    LLENO      = 1'b1
  } estado_t;

  function automatic int unsigned ancho_trama(input int unsigned ancho, input bit paridad);
    return paridad ? ancho + 1 : ancho;
  endfunction

endpackage

// File: rtl/desp_entrada.sv
// Serial shift accumulator and bit counter; strobes fin_trama on the edge that samples the last frame bit.
module desp_entrada
  import deserializador_pkg::*;
#(
  parameter int unsigned ANCHO = 4,
  parameter int unsigned TRAMA = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             DIR,
  input  logic             SYNC,
  output logic [ANCHO-1:0] palabra,
  output logic             fin_trama
);

  localparam int unsigned CW = $clog2(TRAMA + 1);

  logic [ANCHO-1:0] parcial;
  logic [ANCHO-1:0] base;
  logic [ANCHO-1:0] desplazado;
  logic [CW-1:0]    cnt;
  logic             es_dato;

  // SYNC makes the current bit the first of a fresh frame, so shift from an empty word.
  always_comb begin
    base       = SYNC ? '0 : parcial;
    desplazado = (DIR == DIR_LSB_PRIMERO) ? {S_IN, base[ANCHO-1:1]}
                                          : {base[ANCHO-2:0], S_IN};
    es_dato    = SYNC || (cnt < CW'(ANCHO));
    palabra    = es_dato ? desplazado : parcial;
    fin_trama  = ENB && !SYNC && (cnt == CW'(TRAMA - 1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      parcial <= '0;
      cnt     <= '0;
    end else if (ENB) begin
      if (fin_trama) begin
        parcial <= '0;
        cnt     <= '0;
      end else begin
        parcial <= palabra;
        cnt     <= SYNC ? CW'(1) : cnt + CW'(1);
      end
    end else if (SYNC) begin
      parcial <= '0;
      cnt     <= '0;
    end
  end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver with one-entry valid/ready output buffer and sticky overrun flag.
// Optional even-parity check when DESERIALIZADOR_PARIDAD_EN is defined.
module deserializador
  import deserializador_pkg::*;
#(
  parameter int unsigned ANCHO = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             DIR,
  input  logic             SYNC,
  input  logic             LISTO,
  input  logic             CLR_OVF,
  output logic [ANCHO-1:0] Q,
  output logic             VALID,
  output logic             OVF,
  output logic             ERR_PAR
);

`ifdef DESERIALIZADOR_PARIDAD_EN
  localparam bit PARIDAD = 1'b1;
`else
  localparam bit PARIDAD = 1'b0;
`endif
  localparam int unsigned TRAMA = ancho_trama(ANCHO, PARIDAD);

  logic [ANCHO-1:0] palabra;
  logic             fin_trama;
  logic             trama_ok;
  logic             acepta;
  logic             cargar;
  logic             rebalse;
  estado_t          estado;
  estado_t          estado_sig;

  desp_entrada #(
    .ANCHO(ANCHO),
    .TRAMA(TRAMA)
  ) u_desp (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENB      (ENB),
    .S_IN     (S_IN),
    .DIR      (DIR),
    .SYNC     (SYNC),
    .palabra  (palabra),
    .fin_trama(fin_trama)
  );

`ifdef DESERIALIZADOR_PARIDAD_EN
  // On the completion edge S_IN carries the parity bit; palabra already holds all data bits.
  assign trama_ok = ((^palabra) == S_IN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ERR_PAR <= 1'b0;
    else       ERR_PAR <= fin_trama && !trama_ok;
  end
`else
  assign trama_ok = 1'b1;
  assign ERR_PAR  = 1'b0;
`endif

  assign acepta = fin_trama && trama_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) estado <= RECIBIENDO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    cargar     = 1'b0;
    rebalse    = 1'b0;
    case (estado)
      RECIBIENDO: begin
        if (acepta) begin
          cargar     = 1'b1;
          estado_sig = LLENO;
        end
      end
      LLENO: begin
        if (acepta && LISTO) cargar = 1'b1;
        else if (acepta)     rebalse = 1'b1;
        else if (LISTO)      estado_sig = RECIBIENDO;
      end
      default: estado_sig = RECIBIENDO;
    endcase
  end

  assign VALID = (estado == LLENO);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q   <= '0;
      OVF <= 1'b0;
    end else begin
      if (cargar)       Q   <= palabra;
      if (rebalse)      OVF <= 1'b1;
      else if (CLR_OVF) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: reference model plus directed literal expectations.
module tb_deserializador;

  localparam int A = 4;
`ifdef DESERIALIZADOR_PARIDAD_EN
  localparam int FRAME = A + 1;
`else
  localparam int FRAME = A;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         ENB = 1'b0;
  logic         S_IN = 1'b0;
  logic         DIR = 1'b0;
  logic         SYNC = 1'b0;
  logic         LISTO = 1'b0;
  logic         CLR_OVF = 1'b0;
  logic [A-1:0] Q;
  logic         VALID;
  logic         OVF;
  logic         ERR_PAR;

  int errors = 0;
  int checks = 0;

  deserializador #(.ANCHO(A)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENB    (ENB),
    .S_IN   (S_IN),
    .DIR    (DIR),
    .SYNC   (SYNC),
    .LISTO  (LISTO),
    .CLR_OVF(CLR_OVF),
    .Q      (Q),
    .VALID  (VALID),
    .OVF    (OVF),
    .ERR_PAR(ERR_PAR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame assembled bit by bit, then buffer/handshake rules applied.
  int m_part = 0, m_cnt = 0, m_q = 0;
  bit m_valid = 0, m_ovf = 0, m_err = 0;

  always @(posedge CLK or posedge RESET) begin
    bit fin, ok, parbit, lleno_antes;
    int word;
    if (RESET) begin
      m_part = 0; m_cnt = 0; m_q = 0; m_valid = 0; m_ovf = 0; m_err = 0;
    end else begin
      fin = 0; ok = 1; parbit = 0; word = 0;
      lleno_antes = m_valid;
      if (SYNC) begin m_part = 0; m_cnt = 0; end
      if (ENB) begin
        if (m_cnt < A) begin
          if (DIR) m_part = (m_part >> 1) | (int'(S_IN) << (A - 1));
          else     m_part = ((m_part << 1) | int'(S_IN)) & ((1 << A) - 1);
        end else parbit = S_IN;
        m_cnt++;
        if (m_cnt == FRAME) begin
          fin = 1; word = m_part; m_part = 0; m_cnt = 0;
        end
      end
`ifdef DESERIALIZADOR_PARIDAD_EN
      if (fin) ok = ($countones(word) % 2) == int'(parbit);
`endif
      m_err = fin && !ok;
      if (CLR_OVF) m_ovf = 0;
      if (fin && ok) begin
        if (!lleno_antes || LISTO) begin m_q = word; m_valid = 1; end
        else m_ovf = 1;
      end else if (lleno_antes && LISTO) m_valid = 0;
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      chk("model_Q", int'(Q), m_q);
      chk("model_VALID", int'(VALID), int'(m_valid));
      chk("model_OVF", int'(OVF), int'(m_ovf));
      chk("model_ERR_PAR", int'(ERR_PAR), int'(m_err));
    end
  end

  task automatic step(input logic en, input logic s, input logic d, input logic sy);
    ENB = en; S_IN = s; DIR = d; SYNC = sy;
    @(posedge CLK);
    #1;
    ENB = 1'b0; SYNC = 1'b0;
  endtask

  // seq is in time order, leftmost bit first; parity bit appended when enabled.
  task automatic send_seq(input logic [A-1:0] seq, input logic d, input logic sync_first);
    for (int i = A - 1; i >= 0; i--) step(1'b1, seq[i], d, sync_first && (i == A - 1));
`ifdef DESERIALIZADOR_PARIDAD_EN
    step(1'b1, ^seq, d, 1'b0);
`endif
  endtask

  initial begin
    #12;
    chk("reset_Q", int'(Q), 0);
    chk("reset_VALID", int'(VALID), 0);
    chk("reset_OVF", int'(OVF), 0);
    chk("reset_ERR_PAR", int'(ERR_PAR), 0);
    RESET = 1'b0;

    LISTO = 1'b1;
    send_seq(4'b1011, 1'b0, 1'b0);
    chk("msb_Q", int'(Q), 'b1011);
    chk("msb_VALID", int'(VALID), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("msb_consumed", int'(VALID), 0);

    send_seq(4'b1011, 1'b1, 1'b0);
    chk("lsb_Q", int'(Q), 'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    LISTO = 1'b0;
    send_seq(4'b1011, 1'b0, 1'b0);
    send_seq(4'b0110, 1'b0, 1'b0);
    chk("ovr_Q", int'(Q), 'b1011);
    chk("ovr_OVF", int'(OVF), 1);
    chk("ovr_VALID", int'(VALID), 1);
    LISTO = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_release_VALID", int'(VALID), 0);
    chk("ovr_sticky_OVF", int'(OVF), 1);
    CLR_OVF = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    CLR_OVF = 1'b0;
    chk("ovr_clear_OVF", int'(OVF), 0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(4'b0110, 1'b0, 1'b0);
    chk("sync_idle_Q", int'(Q), 'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send_seq(4'b0110, 1'b0, 1'b1);
    chk("sync_enb_Q", int'(Q), 'b0110);
    chk("sync_enb_VALID", int'(VALID), 1);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_Q", int'(Q), 0);
    chk("rst_mid_VALID", int'(VALID), 0);
    chk("rst_mid_OVF", int'(OVF), 0);
    RESET = 1'b0;
    send_seq(4'b0011, 1'b0, 1'b0);
    chk("rst_after_Q", int'(Q), 'b0011);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mixed direction within one frame: R,L,L,R of 1,1,0,1 -> 1000,0001,0010,1001.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef DESERIALIZADOR_PARIDAD_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
`endif
    chk("mixed_dir_Q", int'(Q), 'b1001);
    step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DESERIALIZADOR_PARIDAD_EN
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_ok_Q", int'(Q), 'b1011);
    chk("par_ok_ERR", int'(ERR_PAR), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_bad_VALID", int'(VALID), 0);
    chk("par_bad_ERR", int'(ERR_PAR), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_err_pulse_end", int'(ERR_PAR), 0);
`endif

    for (int i = 0; i < 200; i++) begin
      LISTO   = ($urandom % 3) != 0;
      CLR_OVF = ($urandom % 8) == 0;
      step(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 16) == 0);
    end
    CLR_OVF = 1'b0;

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
